mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and widths for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } stateE;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } grantE;

  // A tie goes to whoever was not served last.
  function automatic grantE pickGrant(input logic reqF, input logic reqD, input grantE last);
    if (reqF && reqD) return (last == GNT_F) ? GNT_D : GNT_F;
    else if (reqD)    return GNT_D;
    else              return GNT_F;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_f,
  input  logic [ADDR_W-1:0] addr_f,
  output logic              ack_f,
  input  logic              req_d,
  input  logic              we_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic              ack_d,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  stateE             state, stateNext;
  grantE             gnt, gntNext, last, lastNext, grantSel;
  logic              grantEn;
  logic [3:0]        cnt, cntNext;
  logic [DATA_W-1:0] rdataQ, rdataNext;
  logic [ADDR_W-1:0] latAddr, latAddrNext;
  logic              latWe, latWeNext;
  logic [DATA_W-1:0] latWdata, latWdataNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= GNT_F;
      last     <= GNT_D;
      cnt      <= '0;
      rdataQ   <= '0;
      latAddr  <= '0;
      latWe    <= 1'b0;
      latWdata <= '0;
    end else begin
      state    <= stateNext;
      gnt      <= gntNext;
      last     <= lastNext;
      cnt      <= cntNext;
      rdataQ   <= rdataNext;
      latAddr  <= latAddrNext;
      latWe    <= latWeNext;
      latWdata <= latWdataNext;
    end
  end

  always_comb begin
    stateNext    = state;
    gntNext      = gnt;
    lastNext     = last;
    cntNext      = cnt;
    rdataNext    = rdataQ;
    latAddrNext  = latAddr;
    latWeNext    = latWe;
    latWdataNext = latWdata;
    grantEn      = 1'b0;
    grantSel     = gnt;

    case (state)
      IDLE: begin
        if (req_f || req_d) begin
          grantEn  = 1'b1;
          grantSel = pickGrant(req_f, req_d, last);
        end
      end
      ACCESS: begin
        cntNext = cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          cntNext   = '0;
          stateNext = RESP;
          if (!latWe) rdataNext = mem_rdata;
        end
      end
      RESP: begin
        // The served side still holds req while seeing its ack, so only the other side may chain.
        lastNext  = gnt;
        stateNext = IDLE;
        if ((gnt == GNT_F) ? req_d : req_f) begin
          grantEn  = 1'b1;
          grantSel = (gnt == GNT_F) ? GNT_D : GNT_F;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (grantEn) begin
      gntNext      = grantSel;
      stateNext    = ACCESS;
      cntNext      = '0;
      latAddrNext  = (grantSel == GNT_D) ? addr_d : addr_f;
      latWeNext    = (grantSel == GNT_D) && we_d;
      latWdataNext = (grantSel == GNT_D) ? wdata_d : '0;
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && latWe;
  assign mem_addr  = mem_en ? latAddr : '0;
  assign mem_wdata = mem_en ? latWdata : '0;
  assign ack_f     = (state == RESP) && (gnt == GNT_F);
  assign ack_d     = (state == RESP) && (gnt == GNT_D);
  assign busy      = (state != IDLE);
  assign rdata     = rdataQ;

endmodule
